// File: rtl/mdu_pkg.sv
// Shared MDU definitions: funct3 op encodings, multiplier FSM states and Booth digit recoding.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t BD_ZERO = 3'b000;
  localparam booth_digit_t BD_P1   = 3'b001;
  localparam booth_digit_t BD_P2   = 3'b010;
  localparam booth_digit_t BD_M2   = 3'b110;
  localparam booth_digit_t BD_M1   = 3'b111;

  // Radix-4 Booth recoding of {b1, b0, b-1}.
  function automatic booth_digit_t booth_recode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_recoder.sv
// Combinational Booth recoder: turns a 3-bit multiplier window into the partial product d*A_ext.
module booth4_recoder
  import mdu_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic [2:0]   sel,
  input  logic [N+1:0] a_ext,
  output logic [N+2:0] pp
);

  localparam int unsigned PW = N + 3;

  booth_digit_t  digit;
  logic [PW-1:0] mag;

  always_comb begin
    digit = booth_recode(sel);
    mag   = '0;
    unique case (digit)
      BD_P1, BD_M1: mag = {a_ext[N+1], a_ext};
      BD_P2, BD_M2: mag = {a_ext, 1'b0};
      default:      mag = '0;
    endcase
    // Negative digits negate in two's complement: invert plus one.
    pp = digit[2] ? (~mag + PW'(1)) : mag;
  end

endmodule

// File: rtl/booth4_mul.sv
// Sequential radix-4 Booth multiplier for RV32IM MUL/MULH/MULHSU/MULHU, two multiplier bits per cycle.
module booth4_mul
  import mdu_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  input  logic [1:0]   op,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned EW    = N + 2;
  localparam int unsigned HW    = N + 3;
  localparam int unsigned STEPS = (N + 2) / 2;
  localparam int unsigned CW    = $clog2(STEPS);

  mul_state_t    state, state_nxt;
  mdu_op_t       op_q, op_nxt, op_in;
  logic [EW-1:0] a_q, a_nxt;
  logic [HW-1:0] h_q, h_nxt;
  logic [EW-1:0] l_q, l_nxt;
  logic          q_q, q_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [N-1:0]  out_nxt;
  logic          done_nxt;

  logic [HW-1:0]  pp;
  logic [HW-1:0]  sum;
  logic [2*N-1:0] prod;
  logic           a_signed, b_signed;

  booth4_recoder #(.N(N)) u_recoder (
    .sel   ({l_q[1:0], q_q}),
    .a_ext (a_q),
    .pp    (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= OP_MUL;
      a_q   <= '0;
      h_q   <= '0;
      l_q   <= '0;
      q_q   <= 1'b0;
      cnt_q <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      a_q   <= a_nxt;
      h_q   <= h_nxt;
      l_q   <= l_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_nxt;
      out   <= out_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    a_nxt     = a_q;
    h_nxt     = h_q;
    l_nxt     = l_q;
    q_nxt     = q_q;
    cnt_nxt   = cnt_q;
    out_nxt   = out;
    done_nxt  = 1'b0;

    op_in    = mdu_op_t'({1'b0, op});
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    b_signed = (op_in == OP_MULH);
    sum      = h_q + pp;
    // Low 2N bits of the {H,L} product; H's top bits only hold sign extension.
    prod     = {h_q[N-3:0], l_q};

    unique case (state)
      IDLE: begin
        if (start) begin
          op_nxt    = op_in;
          a_nxt     = {{2{a_signed & multiplicand[N-1]}}, multiplicand};
          l_nxt     = {{2{b_signed & multiplier[N-1]}}, multiplier};
          h_nxt     = '0;
          q_nxt     = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Accumulate, then arithmetic-shift {H,L,q} right by two.
        h_nxt   = {{2{sum[HW-1]}}, sum[HW-1:2]};
        l_nxt   = {sum[1:0], l_q[EW-1:2]};
        q_nxt   = l_q[1];
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_nxt   = (op_q == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
